wb_arbiter_n: RTL and testbench

- Parametrised N-master to 1-slave Wishbone classic arbiter. It is the successor to the fixed 3-port arbiter.
- Adds the following over the 3-port version:
  - configurable master count;
  - registered grant FSM;
  - selectable fixed-priority or round-robin arbitration;
  - per-cycle bus watchdog that aborts a hung slave access with an error to the owning master;
  - error pass-through.
- Sits between core/DMA masters and the interconnect/slave decoder.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_arbiter_n_if.sv | 42 ++++
 rtl/rr_priority_enc.sv | 37 +++
 rtl/wb_arbiter_n.sv | 165 ++++++++++++++++
 tb/tb_wb_arbiter_n.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone N-master arbiter: FSM encoding,
// the constant-safe clog2 helper and the default watchdog limit.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2,
    ST_DRAIN = 2'd3
  } wb_state_e;

  localparam int WB_DEFAULT_TIMEOUT = 255;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_arbiter_n_if.sv
// Bundle of all master-side and slave-side Wishbone signals around the arbiter.
// Handshake: a master's transfer completes in the cycle it sees ack or err while its stb and cyc are high.
interface wb_arbiter_n_if #(
    parameter int NUM_MASTERS  = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [NUM_MASTERS*ADDR_WIDTH-1:0]   wbm_adr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0]   wbm_dat_i;
    logic [DATA_WIDTH-1:0]               wbm_dat_o;
    logic [NUM_MASTERS-1:0]              wbm_we_i;
    logic [NUM_MASTERS*SELECT_WIDTH-1:0] wbm_sel_i;
    logic [NUM_MASTERS-1:0]              wbm_stb_i;
    logic [NUM_MASTERS-1:0]              wbm_cyc_i;
    logic [NUM_MASTERS-1:0]              wbm_ack_o;
    logic [NUM_MASTERS-1:0]              wbm_err_o;
    logic [ADDR_WIDTH-1:0]               wbs_adr_o;
    logic [DATA_WIDTH-1:0]               wbs_dat_o;
    logic [DATA_WIDTH-1:0]               wbs_dat_i;
    logic                                wbs_we_o;
    logic [SELECT_WIDTH-1:0]             wbs_sel_o;
    logic                                wbs_stb_o;
    logic                                wbs_cyc_o;
    logic                                wbs_ack_i;
    logic                                wbs_err_i;

    // slave: the arbiter's view; master: the cores and downstream slave around it
    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o,
        output wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
        output wbs_dat_i, wbs_ack_i, wbs_err_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o,
        input  wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o
    );
endinterface

// File: rtl/rr_priority_enc.sv
// N-wide priority encoder whose search origin is rotated by a pointer.
// LSB_HIGH scans ptr, ptr+1, ...; otherwise scans ptr-1, ptr-2, ... (wrapping).
module rr_priority_enc
    import wb_pkg::*;
#(
    parameter int N        = 4,
    parameter int LSB_HIGH = 1,
    localparam int PW      = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int k;
        logic [PW-1:0] k_sel;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        k      = 0;
        k_sel  = '0;
        for (int i = 0; i < N; i++) begin
            if (LSB_HIGH != 0) k = (int'(ptr) + i) % N;
            else               k = (int'(ptr) - 1 - i + 2 * N) % N;
            k_sel = PW'(k);
            if (!valid && req[k_sel]) begin
                valid         = 1'b1;
                onehot[k_sel] = 1'b1;
                idx           = k_sel;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone classic arbiter with registered grant,
// fixed-priority or round-robin selection and a stalled-slave watchdog.
module wb_arbiter_n
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS       = 4,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int SELECT_WIDTH      = DATA_WIDTH / 8,
    parameter int ARB_ROUND_ROBIN   = 0,
    parameter int LSB_HIGH_PRIORITY = 1,
    parameter int TIMEOUT_CYCLES    = WB_DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wb_arbiter_n_if.slave          bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   timeout_o,
    output wb_state_e              state_dbg
);

    localparam int PW     = (NUM_MASTERS > 1) ? clog2(NUM_MASTERS) : 1;
    localparam int CW_RAW = clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW > 0) ? CW_RAW : 1;

    wb_state_e              state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [PW-1:0]          owner_q;
    logic [PW-1:0]          ptr_q;
    logic [CW-1:0]          wdog_q;

    logic [NUM_MASTERS-1:0] enc_onehot;
    logic [PW-1:0]          enc_idx;
    logic                   enc_valid;
    logic [PW-1:0]          arb_ptr;
    logic [PW-1:0]          ptr_after;

    logic [ADDR_WIDTH-1:0]   adr_mux;
    logic [DATA_WIDTH-1:0]   dat_mux;
    logic [SELECT_WIDTH-1:0] sel_mux;
    logic                    we_mux;
    logic                    owner_cyc;
    logic                    owner_stb;
    logic                    stall;
    logic                    expire;
    logic                    release_grant;

    assign arb_ptr = (ARB_ROUND_ROBIN != 0) ? ptr_q : '0;

    rr_priority_enc #(
        .N        (NUM_MASTERS),
        .LSB_HIGH (LSB_HIGH_PRIORITY)
    ) u_enc (
        .req    (bus.wbm_cyc_i),
        .ptr    (arb_ptr),
        .onehot (enc_onehot),
        .idx    (enc_idx),
        .valid  (enc_valid)
    );

    // AND-OR mux keyed by the one-hot grant; nothing is selected while grant is zero.
    always_comb begin
        adr_mux   = '0;
        dat_mux   = '0;
        sel_mux   = '0;
        we_mux    = 1'b0;
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                adr_mux   = bus.wbm_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                dat_mux   = bus.wbm_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                sel_mux   = bus.wbm_sel_i[k*SELECT_WIDTH +: SELECT_WIDTH];
                we_mux    = bus.wbm_we_i[k];
                owner_cyc = bus.wbm_cyc_i[k];
                owner_stb = bus.wbm_stb_i[k];
            end
        end
    end

    assign stall  = (state_q == ST_GRANT) && owner_stb && !bus.wbs_ack_i && !bus.wbs_err_i;
    assign expire = (TIMEOUT_CYCLES != 0) && stall && (wdog_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Owner dropping cyc takes precedence over a simultaneous watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enc_valid) state_d = ST_GRANT;
            ST_GRANT: begin
                if (!owner_cyc)  state_d = ST_IDLE;
                else if (expire) state_d = ST_ABORT;
            end
            ST_ABORT: state_d = ST_DRAIN;
            ST_DRAIN: if (!owner_cyc) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.wbs_cyc_o = 1'b0;
        bus.wbs_stb_o = 1'b0;
        bus.wbs_adr_o = '0;
        bus.wbs_dat_o = '0;
        bus.wbs_sel_o = '0;
        bus.wbs_we_o  = 1'b0;
        bus.wbm_ack_o = '0;
        bus.wbm_err_o = '0;
        timeout_o     = 1'b0;
        case (state_q)
            ST_GRANT: begin
                bus.wbs_cyc_o = 1'b1;
                bus.wbs_stb_o = owner_stb;
                bus.wbs_adr_o = adr_mux;
                bus.wbs_dat_o = dat_mux;
                bus.wbs_sel_o = sel_mux;
                bus.wbs_we_o  = we_mux;
                bus.wbm_ack_o = grant_q & {NUM_MASTERS{bus.wbs_ack_i}};
                bus.wbm_err_o = grant_q & {NUM_MASTERS{bus.wbs_err_i}};
            end
            ST_ABORT: begin
                bus.wbm_err_o = grant_q;
                timeout_o     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.wbm_dat_o = bus.wbs_dat_i;
    assign grant_o       = grant_q;
    assign state_dbg     = state_q;

    assign release_grant = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    assign ptr_after = (LSB_HIGH_PRIORITY != 0)
                     ? ((owner_q == PW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1)
                     : owner_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            wdog_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && enc_valid) begin
                grant_q <= enc_onehot;
                owner_q <= enc_idx;
            end else if (release_grant) begin
                grant_q <= '0;
            end
            if (release_grant && ARB_ROUND_ROBIN != 0) ptr_q <= ptr_after;
            // Saturating stall counter; any ack/err/stb-low or leaving GRANT clears it.
            if (stall) begin
                if (wdog_q != CW'(TIMEOUT_CYCLES)) wdog_q <= wdog_q + 1'b1;
            end else begin
                wdog_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench for wb_arbiter_n: a fixed-priority and a round-robin
// instance, both with an 8-cycle watchdog.
module tb_wb_arbiter_n;
  import wb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  logic [3:0] grant_f, grant_r;
  logic       timeout_f, timeout_r;
  wb_state_e  state_f, state_r;
  logic [3:0] rr_exp [5];

  wb_arbiter_n_if #(.NUM_MASTERS(4)) bf ();
  wb_arbiter_n_if #(.NUM_MASTERS(4)) br ();

  wb_arbiter_n #(
    .NUM_MASTERS(4), .ARB_ROUND_ROBIN(0), .LSB_HIGH_PRIORITY(1), .TIMEOUT_CYCLES(8)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .bus(bf.slave),
    .grant_o(grant_f), .timeout_o(timeout_f), .state_dbg(state_f)
  );

  wb_arbiter_n #(
    .NUM_MASTERS(4), .ARB_ROUND_ROBIN(1), .LSB_HIGH_PRIORITY(1), .TIMEOUT_CYCLES(8)
  ) dut_r (
    .clk(clk), .rst_n(rst_n), .bus(br.slave),
    .grant_o(grant_r), .timeout_o(timeout_r), .state_dbg(state_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    bf.wbm_adr_i = {32'h1000_0300, 32'h1000_0200, 32'h1000_0100, 32'h1000_0000};
    bf.wbm_dat_i = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
    bf.wbm_we_i  = 4'b0000; bf.wbm_sel_i = '1;
    bf.wbm_stb_i = 4'b0000; bf.wbm_cyc_i = 4'b0000;
    bf.wbs_dat_i = 32'hCAFE_F00D; bf.wbs_ack_i = 1'b0; bf.wbs_err_i = 1'b0;
    br.wbm_adr_i = {32'h2000_0300, 32'h2000_0200, 32'h2000_0100, 32'h2000_0000};
    br.wbm_dat_i = '0; br.wbm_we_i = 4'b0000; br.wbm_sel_i = '1;
    br.wbm_stb_i = 4'b0000; br.wbm_cyc_i = 4'b0000;
    br.wbs_dat_i = 32'h0000_1234; br.wbs_ack_i = 1'b0; br.wbs_err_i = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #3;
    chk("rst_grant", grant_f, 4'b0000);
    chk("rst_state", state_f, ST_IDLE);
    chk("rst_wbs_cyc", bf.wbs_cyc_o, 1'b0);
    chk("rst_wbs_stb", bf.wbs_stb_o, 1'b0);
    chk("rst_ack", bf.wbm_ack_o, 4'b0000);
    chk("rst_err", bf.wbm_err_o, 4'b0000);
    chk("rst_timeout", timeout_f, 1'b0);
    chk("rst_dat_passthru", bf.wbm_dat_o, 32'hCAFE_F00D);
    next();
    rst_n = 1'b1;

    // fixed priority: m1 beats m3, then one idle cycle, then m3
    next();
    bf.wbm_cyc_i = 4'b1010; bf.wbm_stb_i = 4'b1010;
    #1;
    chk("fx_latency_cyc", bf.wbs_cyc_o, 1'b0);
    next();
    chk("fx_grant_m1", grant_f, 4'b0010);
    chk("fx_cyc_m1", bf.wbs_cyc_o, 1'b1);
    chk("fx_adr_m1", bf.wbs_adr_o, 32'h1000_0100);
    chk("fx_dat_m1", bf.wbs_dat_o, 32'hD1D1_D1D1);
    bf.wbs_ack_i = 1'b1;
    #1;
    chk("fx_ack_m1", bf.wbm_ack_o, 4'b0010);
    next();
    bf.wbs_ack_i = 1'b0; bf.wbm_cyc_i = 4'b1000; bf.wbm_stb_i = 4'b1000;
    next();
    chk("fx_gap_grant", grant_f, 4'b0000);
    chk("fx_gap_cyc", bf.wbs_cyc_o, 1'b0);
    next();
    chk("fx_grant_m3", grant_f, 4'b1000);
    chk("fx_adr_m3", bf.wbs_adr_o, 32'h1000_0300);
    bf.wbs_ack_i = 1'b1;
    #1;
    chk("fx_ack_m3", bf.wbm_ack_o, 4'b1000);
    next();
    bf.wbs_ack_i = 1'b0; bf.wbm_cyc_i = 4'b0000; bf.wbm_stb_i = 4'b0000;
    next();

    // watchdog abort: m2 never acked
    bf.wbm_cyc_i = 4'b0100; bf.wbm_stb_i = 4'b0100;
    next();
    chk("wd_grant_m2", grant_f, 4'b0100);
    repeat (7) next();
    chk("wd_c8_cyc", bf.wbs_cyc_o, 1'b1);
    chk("wd_c8_timeout", timeout_f, 1'b0);
    next();
    bf.wbs_ack_i = 1'b1;
    #1;
    chk("wd_abort_state", state_f, ST_ABORT);
    chk("wd_abort_err", bf.wbm_err_o, 4'b0100);
    chk("wd_abort_timeout", timeout_f, 1'b1);
    chk("wd_abort_cyc", bf.wbs_cyc_o, 1'b0);
    chk("wd_abort_stb", bf.wbs_stb_o, 1'b0);
    chk("wd_abort_ack_ignored", bf.wbm_ack_o, 4'b0000);
    next();
    chk("wd_drain_state", state_f, ST_DRAIN);
    chk("wd_drain_timeout", timeout_f, 1'b0);
    chk("wd_drain_err", bf.wbm_err_o, 4'b0000);
    chk("wd_drain_ack", bf.wbm_ack_o, 4'b0000);
    chk("wd_drain_cyc", bf.wbs_cyc_o, 1'b0);
    chk("wd_drain_grant", grant_f, 4'b0100);
    bf.wbs_ack_i = 1'b0; bf.wbm_cyc_i = 4'b0000; bf.wbm_stb_i = 4'b0000;
    next();
    chk("wd_back_idle", state_f, ST_IDLE);
    chk("wd_idle_grant", grant_f, 4'b0000);

    // ack on exactly the 8th waiting cycle wins over the watchdog
    bf.wbm_cyc_i = 4'b0100; bf.wbm_stb_i = 4'b0100;
    next();
    repeat (7) next();
    bf.wbs_ack_i = 1'b1;
    #1;
    chk("wd8_ack", bf.wbm_ack_o, 4'b0100);
    chk("wd8_err", bf.wbm_err_o, 4'b0000);
    next();
    bf.wbs_ack_i = 1'b0;
    #1;
    chk("wd8_no_timeout", timeout_f, 1'b0);
    chk("wd8_state", state_f, ST_GRANT);
    chk("wd8_cyc", bf.wbs_cyc_o, 1'b1);

    // owner drops cyc in the expiry cycle: clean return to IDLE
    repeat (7) next();
    bf.wbm_cyc_i = 4'b0000;
    next();
    chk("wddrop_state", state_f, ST_IDLE);
    chk("wddrop_timeout", timeout_f, 1'b0);
    chk("wddrop_err", bf.wbm_err_o, 4'b0000);
    bf.wbm_stb_i = 4'b0000;
    next();

    // slave error for m0 read, m3 waiting
    bf.wbm_cyc_i = 4'b1001; bf.wbm_stb_i = 4'b1001;
    next();
    chk("er_grant_m0", grant_f, 4'b0001);
    bf.wbs_err_i = 1'b1;
    #1;
    chk("er_err_m0", bf.wbm_err_o, 4'b0001);
    chk("er_ack", bf.wbm_ack_o, 4'b0000);
    chk("er_timeout", timeout_f, 1'b0);
    next();
    bf.wbs_err_i = 1'b0; bf.wbm_cyc_i = 4'b0000; bf.wbm_stb_i = 4'b0000;
    next();

    // round robin with all four masters requesting
    br.wbm_cyc_i = 4'b1111; br.wbm_stb_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      next();
      chk($sformatf("rr_grant_%0d", i), grant_r, rr_exp[i]);
      br.wbs_ack_i = 1'b1;
      #1;
      chk($sformatf("rr_ack_%0d", i), br.wbm_ack_o, rr_exp[i]);
      next();
      br.wbs_ack_i = 1'b0;
      br.wbm_cyc_i = 4'b1111 & ~rr_exp[i];
      br.wbm_stb_i = 4'b1111 & ~rr_exp[i];
      next();
      chk($sformatf("rr_gap_%0d", i), grant_r, 4'b0000);
      br.wbm_cyc_i = 4'b1111; br.wbm_stb_i = 4'b1111;
    end

    // reset mid-burst while m0 owns the bus with the pointer at 1
    br.wbm_cyc_i = 4'b0001; br.wbm_stb_i = 4'b0001;
    next();
    chk("rr_m0_again", grant_r, 4'b0001);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rr_rst_cyc", br.wbs_cyc_o, 1'b0);
    chk("rr_rst_grant", grant_r, 4'b0000);
    br.wbm_cyc_i = 4'b0011; br.wbm_stb_i = 4'b0011;
    next();
    chk("rr_rst_held", grant_r, 4'b0000);
    rst_n = 1'b1;
    next();
    chk("rr_post_rst_ptr0", grant_r, 4'b0001);
    br.wbm_cyc_i = 4'b0000; br.wbm_stb_i = 4'b0000;
    next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
